// File: rtl/fft_band_peak_picker_pkg.sv
// Purpose : shared FSM encodings, geometry helpers and the peak record type
//           for the FFT band peak picker.
// Ports   : none (package).
package fft_peak_pkg;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_EMIT  = 2'd3;

  function automatic int f_half_len(input int fft_len);
    return fft_len / 2;
  endfunction

  function automatic int f_band_bins(input int fft_len, input int num_bands);
    return (fft_len / 2) / num_bands;
  endfunction

  function automatic int f_mag_w(input int data_w);
    return 2 * data_w;
  endfunction

  // Geometry at the default configuration (1024-point FFT, 8 bands, 16-bit data)
  localparam int HALF_LEN  = f_half_len(1024);
  localparam int BAND_BINS = f_band_bins(1024, 8);
  localparam int MAG_W     = f_mag_w(16);

  typedef struct packed {
    logic [2:0]       band;
    logic [9:0]       bin;
    logic [MAG_W-1:0] mag;
  } peak_rec_t;

endpackage

// File: rtl/fft_band_peak_picker_if.sv
// Purpose : valid/ready peak record stream from the picker to the hash stage.
// Ports   : peak_valid_o/peak_band_o/peak_bin_o/peak_mag_o driven by master,
//           peak_ready_i driven by slave.
interface fft_band_peak_picker_if #(
  parameter int BAND_W = 3,
  parameter int BIN_W  = 10,
  parameter int MAG_W  = 32
) ();
  logic              peak_valid_o;
  logic              peak_ready_i;
  logic [BAND_W-1:0] peak_band_o;
  logic [BIN_W-1:0]  peak_bin_o;
  logic [MAG_W-1:0]  peak_mag_o;

  modport master (output peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o,
                  input  peak_ready_i);
  modport slave  (input  peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o,
                  output peak_ready_i);
endinterface

// File: rtl/fft_band_peak_picker_mag_sq.sv
// Purpose : 2-stage pipelined re^2 + im^2 with a valid bit and bin tag riding along.
// Ports   : clk/reset; i_vld/i_tag/i_re/i_im in; o_vld/o_tag/o_mag out, 2 cycles later.
//           No backpressure: one sample accepted every cycle.
module fft_mag_sq #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_vld,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic signed [DATA_W-1:0] i_re,
  input  logic signed [DATA_W-1:0] i_im,
  output logic                     o_vld,
  output logic [TAG_W-1:0]         o_tag,
  output logic [2*DATA_W-1:0]      o_mag
);
  logic signed [2*DATA_W-1:0] r_re_sq;
  logic signed [2*DATA_W-1:0] r_im_sq;
  logic                       r_s1_vld;
  logic [TAG_W-1:0]           r_s1_tag;
  logic                       r_s2_vld;
  logic [TAG_W-1:0]           r_s2_tag;
  logic [2*DATA_W-1:0]        r_s2_mag;

  // Squares are non-negative and at most 2^(2*DATA_W-2), so the unsigned sum
  // tops out at 2^(2*DATA_W-1) and never overflows 2*DATA_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_re_sq  <= '0;
      r_im_sq  <= '0;
      r_s1_vld <= 1'b0;
      r_s1_tag <= '0;
      r_s2_vld <= 1'b0;
      r_s2_tag <= '0;
      r_s2_mag <= '0;
    end else begin
      r_re_sq  <= i_re * i_re;
      r_im_sq  <= i_im * i_im;
      r_s1_vld <= i_vld;
      r_s1_tag <= i_tag;
      r_s2_vld <= r_s1_vld;
      r_s2_tag <= r_s1_tag;
      r_s2_mag <= $unsigned(r_re_sq) + $unsigned(r_im_sq);
    end
  end

  assign o_vld = r_s2_vld;
  assign o_tag = r_s2_tag;
  assign o_mag = r_s2_mag;
endmodule

// File: rtl/fft_band_peak_picker.sv
// Purpose : reads the lower half of an FFT frame, keeps the strongest bin per band,
//           then streams qualifying band peaks out over a valid/ready interface.
// Ports   : clk/reset; start_i frame trigger; bin_index_o + fft_real_i/fft_imag_i RAM read port;
//           peak_if record stream (held stable under backpressure); frame_done_o, busy_o, overrun_o.
module fft_band_peak_picker
  import fft_peak_pkg::*;
#(
  parameter int  FFT_LENGTH = 1024,
  parameter int  DATA_W     = 16,
  parameter int  NUM_BANDS  = 8,
  parameter int  RD_LAT     = 1,
  parameter logic [2*DATA_W-1:0] MIN_MAG = (2*DATA_W)'(4096),
  parameter bit  SKIP_DC    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  output logic [$clog2(FFT_LENGTH)-1:0] bin_index_o,
  input  logic signed [DATA_W-1:0]     fft_real_i,
  input  logic signed [DATA_W-1:0]     fft_imag_i,
  fft_band_peak_picker_if.master       peak_if,
  output logic                         frame_done_o,
  output logic                         busy_o,
  output logic                         overrun_o
);
  localparam int P_HALF      = f_half_len(FFT_LENGTH);
  localparam int P_BAND_BINS = f_band_bins(FFT_LENGTH, NUM_BANDS);
  localparam int P_MAG_W     = f_mag_w(DATA_W);
  localparam int AW          = $clog2(FFT_LENGTH);
  localparam int BW          = $clog2(NUM_BANDS);

  state_t             r_state;
  logic [AW-1:0]      r_addr;
  logic [1:0]         r_drain_cnt;
  logic [RD_LAT-1:0]  r_rd_vld;
  logic [AW-1:0]      r_rd_tag [RD_LAT];
  logic [P_MAG_W-1:0] r_band_mag [NUM_BANDS];
  logic [AW-1:0]      r_band_bin [NUM_BANDS];
  logic [BW-1:0]      r_ptr;
  logic               r_scan_done;
  logic               r_pk_vld;
  logic [BW-1:0]      r_pk_band;
  logic [AW-1:0]      r_pk_bin;
  logic [P_MAG_W-1:0] r_pk_mag;
  logic               r_frame_done;
  logic               r_overrun;

  logic               w_m_vld;
  logic [AW-1:0]      w_m_bin;
  logic [P_MAG_W-1:0] w_m_mag;
  int                 w_bin_int;
  logic [BW-1:0]      w_band;
  logic               w_skip;
  logic               w_first;
  logic               w_cur_qual;
  logic               w_rem_qual;
  logic               w_out_free;

  // Address tag and valid follow the RAM read latency so they line up with the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_rd_tag[i] <= '0;
    end else begin
      r_rd_vld[0] <= (r_state == ST_READ);
      r_rd_tag[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_tag[i] <= r_rd_tag[i-1];
      end
    end
  end

  fft_mag_sq #(.DATA_W(DATA_W), .TAG_W(AW)) u_mag_sq (
    .clk   (clk),
    .reset (reset),
    .i_vld (r_rd_vld[RD_LAT-1]),
    .i_tag (r_rd_tag[RD_LAT-1]),
    .i_re  (fft_real_i),
    .i_im  (fft_imag_i),
    .o_vld (w_m_vld),
    .o_tag (w_m_bin),
    .o_mag (w_m_mag)
  );

  // With DC skipped, bin 1 takes over as the seed of band 0.
  assign w_bin_int = int'(w_m_bin);
  assign w_band    = BW'(w_bin_int / P_BAND_BINS);
  assign w_skip    = SKIP_DC && (w_m_bin == '0);
  assign w_first   = (SKIP_DC && (w_m_bin == AW'(1))) || ((w_bin_int % P_BAND_BINS) == 0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_band_mag[b] <= '0;
        r_band_bin[b] <= '0;
      end
    end else if (w_m_vld && !w_skip && (w_first || (w_m_mag > r_band_mag[w_band]))) begin
      r_band_mag[w_band] <= w_m_mag;
      r_band_bin[w_band] <= w_m_bin;
    end
  end

  // Look ahead over the bands not yet scanned so frame_done can follow the
  // final transfer directly instead of waiting for the skip walk to finish.
  always_comb begin
    w_rem_qual = 1'b0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (!r_scan_done && (b >= int'(r_ptr)) && (r_band_mag[b] >= MIN_MAG)) w_rem_qual = 1'b1;
    end
  end

  assign w_cur_qual = (r_band_mag[r_ptr] >= MIN_MAG);
  assign w_out_free = !r_pk_vld || peak_if.peak_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_drain_cnt  <= '0;
      r_ptr        <= '0;
      r_scan_done  <= 1'b0;
      r_pk_vld     <= 1'b0;
      r_pk_band    <= '0;
      r_pk_bin     <= '0;
      r_pk_mag     <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // A start during a frame, or coinciding with its done pulse, is dropped.
      if (start_i && ((r_state != ST_IDLE) || r_frame_done)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start_i && !r_frame_done) begin
            r_state <= ST_READ;
            r_addr  <= '0;
          end
        end
        ST_READ: begin
          if (r_addr == AW'(P_HALF - 1)) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 2'(RD_LAT + 1)) begin
            r_state     <= ST_EMIT;
            r_ptr       <= '0;
            r_scan_done <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_EMIT: begin
          if (w_out_free) begin
            if (!w_rem_qual) begin
              r_pk_vld     <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_pk_vld <= w_cur_qual;
              if (w_cur_qual) begin
                r_pk_band <= r_ptr;
                r_pk_bin  <= r_band_bin[r_ptr];
                r_pk_mag  <= r_band_mag[r_ptr];
              end
              if (r_ptr == BW'(NUM_BANDS - 1)) r_scan_done <= 1'b1;
              else                             r_ptr       <= r_ptr + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bin_index_o          = r_addr;
  assign peak_if.peak_valid_o = r_pk_vld;
  assign peak_if.peak_band_o  = r_pk_band;
  assign peak_if.peak_bin_o   = r_pk_bin;
  assign peak_if.peak_mag_o   = r_pk_mag;
  assign frame_done_o         = r_frame_done;
  assign busy_o               = (r_state != ST_IDLE);
  assign overrun_o            = r_overrun;
endmodule

// File: tb/tb_fft_band_peak_picker.sv
// Purpose : directed bench for fft_band_peak_picker with a 1-cycle-latency FFT RAM model.
// Ports   : none (top-level bench).
module tb_fft_band_peak_picker;
  import fft_peak_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start_i;
  logic [9:0] bin_index_o;
  logic signed [15:0] fft_real_i, fft_imag_i;
  logic frame_done_o, busy_o, overrun_o;

  fft_band_peak_picker_if #(.BAND_W(3), .BIN_W(10), .MAG_W(32)) pk_if ();

  fft_band_peak_picker dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .bin_index_o  (bin_index_o),
    .fft_real_i   (fft_real_i),
    .fft_imag_i   (fft_imag_i),
    .peak_if      (pk_if),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  // FFT output RAM, read latency 1
  logic signed [15:0] re_mem [0:511];
  logic signed [15:0] im_mem [0:511];
  always @(posedge clk) begin
    fft_real_i <= re_mem[bin_index_o[8:0]];
    fft_imag_i <= im_mem[bin_index_o[8:0]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Transfer collector and hold-stability monitor
  peak_rec_t recs[$];
  peak_rec_t held;
  bit        hold_prev = 1'b0;
  int        stab_err = 0;
  int        fd_cnt = 0;
  time       fd_t = 0;
  time       last_xfer_t = 0;

  always @(posedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!pk_if.peak_valid_o || pk_if.peak_band_o != held.band ||
                        pk_if.peak_bin_o != held.bin || pk_if.peak_mag_o != held.mag))
        stab_err++;
      if (pk_if.peak_valid_o && pk_if.peak_ready_i) begin
        recs.push_back('{band: pk_if.peak_band_o, bin: pk_if.peak_bin_o, mag: pk_if.peak_mag_o});
        last_xfer_t = $time;
      end
      if (frame_done_o) begin
        fd_cnt++;
        fd_t = $time;
      end
      hold_prev = pk_if.peak_valid_o && !pk_if.peak_ready_i;
      held      = '{band: pk_if.peak_band_o, bin: pk_if.peak_bin_o, mag: pk_if.peak_mag_o};
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      re_mem[i] = '0;
      im_mem[i] = '0;
    end
  endtask

  task automatic set_bin(input int b, input int re, input int im);
    re_mem[b] = 16'(re);
    im_mem[b] = 16'(im);
  endtask

  task automatic load_per_band();
    clear_mem();
    for (int k = 0; k < 8; k++) set_bin(64*k + 10, 200, -300);
  endtask

  // Runs one frame. Cycle n is the cycle after the n-th edge following the start edge.
  task automatic run_frame(input int stall_at, input int stall_len, input int restart_at,
                           output int first_vld, output int done_cyc);
    int cyc;
    first_vld = -1;
    done_cyc  = -1;
    recs.delete();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (cyc < 2000 && done_cyc < 0) begin
      pk_if.peak_ready_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0;
      if (pk_if.peak_valid_o && first_vld < 0) first_vld = cyc;
      if (frame_done_o) done_cyc = cyc;
      if (cyc == restart_at) start_i = 1'b1;
    end
    pk_if.peak_ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++; if (pk_if.peak_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pk_if.peak_valid_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_tests++; if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done_o); end
    n_tests++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
    n_tests++; if (bin_index_o !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bin_index_o); end
    n_tests++; if (pk_if.peak_mag_o !== 32'd0) begin n_fail++; $display("FAIL reset_mag: got %0d want 0", pk_if.peak_mag_o); end
  endtask

  task automatic test_tone();
    int fv, dc;
    clear_mem();
    set_bin(37, 1000, 0);
    run_frame(-1, 0, -1, fv, dc);
    n_tests++; if (fv !== 516) begin n_fail++; $display("FAIL tone_latency: got %0d want 516", fv); end
    n_tests++; if (dc !== 517) begin n_fail++; $display("FAIL tone_done_cycle: got %0d want 517", dc); end
    n_tests++; if (recs.size() !== 1) begin n_fail++; $display("FAIL tone_count: got %0d want 1", recs.size()); end
    if (recs.size() > 0) begin
      n_tests++; if (recs[0].band !== 3'd0) begin n_fail++; $display("FAIL tone_band: got %0d want 0", recs[0].band); end
      n_tests++; if (recs[0].bin !== 10'd37) begin n_fail++; $display("FAIL tone_bin: got %0d want 37", recs[0].bin); end
      n_tests++; if (recs[0].mag !== 32'd1_000_000) begin n_fail++; $display("FAIL tone_mag: got %0d want 1000000", recs[0].mag); end
    end
  endtask

  task automatic test_per_band();
    int fv, dc;
    load_per_band();
    run_frame(-1, 0, -1, fv, dc);
    n_tests++; if (recs.size() !== 8) begin n_fail++; $display("FAIL band_count: got %0d want 8", recs.size()); end
    n_tests++; if (dc !== 524) begin n_fail++; $display("FAIL band_done_cycle: got %0d want 524", dc); end
    for (int k = 0; k < recs.size() && k < 8; k++) begin
      n_tests++;
      if (recs[k].band !== 3'(k) || recs[k].bin !== 10'(64*k + 10) || recs[k].mag !== 32'd130_000) begin
        n_fail++;
        $display("FAIL band_rec%0d: got band %0d bin %0d mag %0d want band %0d bin %0d mag 130000",
                 k, recs[k].band, recs[k].bin, recs[k].mag, k, 64*k + 10);
      end
    end
  endtask

  task automatic test_tie_dc();
    int fv, dc;
    clear_mem();
    set_bin(0, 30000, 0);
    set_bin(5, 100, 100);
    set_bin(9, 100, 100);
    run_frame(-1, 0, -1, fv, dc);
    n_tests++; if (recs.size() !== 1) begin n_fail++; $display("FAIL tie_count: got %0d want 1", recs.size()); end
    if (recs.size() > 0) begin
      n_tests++; if (recs[0].bin !== 10'd5) begin n_fail++; $display("FAIL tie_bin: got %0d want 5", recs[0].bin); end
      n_tests++; if (recs[0].mag !== 32'd20_000) begin n_fail++; $display("FAIL tie_mag: got %0d want 20000", recs[0].mag); end
    end
  endtask

  task automatic test_extreme();
    int fv, dc;
    clear_mem();
    set_bin(300, -32768, -32768);
    set_bin(150, 63, 9);   // 4050, just under threshold
    set_bin(400, 64, 0);   // 4096, exactly at threshold
    run_frame(-1, 0, -1, fv, dc);
    n_tests++; if (recs.size() !== 2) begin n_fail++; $display("FAIL ext_count: got %0d want 2", recs.size()); end
    if (recs.size() > 1) begin
      n_tests++;
      if (recs[0].band !== 3'd4 || recs[0].bin !== 10'd300 || recs[0].mag !== 32'h8000_0000) begin
        n_fail++; $display("FAIL ext_max: got band %0d bin %0d mag %h want band 4 bin 300 mag 80000000",
                           recs[0].band, recs[0].bin, recs[0].mag);
      end
      n_tests++;
      if (recs[1].band !== 3'd6 || recs[1].bin !== 10'd400 || recs[1].mag !== 32'd4096) begin
        n_fail++; $display("FAIL ext_threshold: got band %0d bin %0d mag %0d want band 6 bin 400 mag 4096",
                           recs[1].band, recs[1].bin, recs[1].mag);
      end
    end
  endtask

  task automatic test_backpressure();
    int fv, dc, fd0, se0;
    load_per_band();
    fd0 = fd_cnt;
    se0 = stab_err;
    run_frame(518, 10, -1, fv, dc);
    n_tests++; if (recs.size() !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", recs.size()); end
    for (int k = 0; k < recs.size() && k < 8; k++) begin
      n_tests++;
      if (recs[k].band !== 3'(k) || recs[k].bin !== 10'(64*k + 10)) begin
        n_fail++; $display("FAIL bp_rec%0d: got band %0d bin %0d want band %0d bin %0d",
                           k, recs[k].band, recs[k].bin, k, 64*k + 10);
      end
    end
    n_tests++; if (stab_err - se0 !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d hold violations want 0", stab_err - se0); end
    n_tests++; if (dc !== 534) begin n_fail++; $display("FAIL bp_done_cycle: got %0d want 534", dc); end
    n_tests++; if (fd_t !== last_xfer_t + 10) begin n_fail++; $display("FAIL bp_done_after_xfer: got %0t want %0t", fd_t, last_xfer_t + 10); end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d want 1", fd_cnt - fd0); end
  endtask

  task automatic test_overrun();
    int fv, dc;
    clear_mem();
    set_bin(37, 1000, 0);
    run_frame(-1, 0, 100, fv, dc);
    n_tests++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
    n_tests++; if (dc !== 517) begin n_fail++; $display("FAIL ovr_done_cycle: got %0d want 517", dc); end
    n_tests++; if (recs.size() !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", recs.size()); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ovr_no_restart: busy got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid_emit();
    int fv, dc, fd0;
    load_per_band();
    fd0 = fd_cnt;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (518) @(posedge clk);
    #1;
    n_tests++; if (pk_if.peak_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", pk_if.peak_valid_o); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (pk_if.peak_valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0 || frame_done_o !== 1'b0 ||
        pk_if.peak_bin_o !== 10'd0 || pk_if.peak_band_o !== 3'd0 || pk_if.peak_mag_o !== 32'd0 || bin_index_o !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_outputs: got valid %b busy %b ovr %b done %b bin %0d band %0d mag %0d addr %0d want all 0",
               pk_if.peak_valid_o, busy_o, overrun_o, frame_done_o, pk_if.peak_bin_o,
               pk_if.peak_band_o, pk_if.peak_mag_o, bin_index_o);
    end
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_tests++; if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses want 0", fd_cnt - fd0); end
    clear_mem();
    set_bin(37, 1000, 0);
    run_frame(-1, 0, -1, fv, dc);
    n_tests++; if (fv !== 516) begin n_fail++; $display("FAIL rst_clean_latency: got %0d want 516", fv); end
    n_tests++;
    if (recs.size() !== 1) begin
      n_fail++; $display("FAIL rst_clean_count: got %0d want 1", recs.size());
    end else if (recs[0].bin !== 10'd37 || recs[0].mag !== 32'd1_000_000) begin
      n_fail++; $display("FAIL rst_clean_rec: got bin %0d mag %0d want bin 37 mag 1000000", recs[0].bin, recs[0].mag);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start_i = 1'b0;
    pk_if.peak_ready_i = 1'b1;
    clear_mem();
    test_reset();
    test_tone();
    test_per_band();
    test_tie_dc();
    test_extreme();
    test_backpressure();
    test_overrun();
    test_reset_mid_emit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
